osd_dii_pkt_buffer: RTL and testbench
=====================================

OSD_DII_PKT_BUFFER -- requirements
Module: osd_dii_pkt_buffer

Interface
REQ-001 Parameter: DEPTH, 16, flit storage entries; power of two, >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: debug_in  input  dii_flit  upstream DII flit (valid, last, data[15:0]).
REQ-005 Port: debug_in_ready  output  1  buffer accepts debug_in this cycle.
REQ-006 Port: debug_out  output  dii_flit  flit toward the downstream debug processor.
REQ-007 Port: debug_out_ready  input  1  downstream accepts debug_out this cycle.
REQ-008 Port: pkt_count  output  $clog2(DEPTH)+1  number of complete packets (last flit written) held in the buffer.
REQ-009 Port: overflow  output  1  one-cycle pulse on entry to CUT state.

Function
REQ-010 Storage SHALL be a DEPTH-entry circular buffer of {last, data}, with read and write pointers of $clog2(DEPTH)+1 bits including a wrap bit.
REQ-011 Empty SHALL be pointers equal; full SHALL be pointers differing only in the wrap bit.
REQ-012 debug_in_ready SHALL equal !full, with no bypass: a write is never accepted when full, even if a read occurs in the same cycle.
REQ-013 A write SHALL occur when debug_in.valid && debug_in_ready; a read SHALL occur when debug_out.valid && debug_out_ready.
REQ-014 pkt_count SHALL increment on a write with last=1 and decrement on a read with last=1.
REQ-015 pkt_count SHALL be unchanged when both events occur in the same cycle.
REQ-016 FSM states SHALL be STORE (store-and-forward) and CUT (cut-through).
REQ-017 In STORE, debug_out.valid SHALL be !empty && pkt_count != 0.
REQ-018 In CUT, debug_out.valid SHALL be !empty.
REQ-019 STORE -> CUT SHALL occur when full && pkt_count == 0, i.e. an oversize packet; overflow SHALL be asserted in that transition cycle only.
REQ-020 CUT -> STORE SHALL occur on the cycle a flit with last=1 is read.
REQ-021 In CUT, writes SHALL continue whenever not full.
REQ-022 debug_out.data and debug_out.last SHALL be the entry at the read pointer; their value is don't-care when debug_out.valid=0.
REQ-023 Latency: a flit written in cycle N SHALL be presentable no earlier than cycle N+1; there is no combinational input-to-output path.
REQ-024 Flit order SHALL be preserved exactly; no flit is dropped, duplicated or modified.
REQ-025 Pointers SHALL wrap modulo 2*DEPTH with no gap at the wrap.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL clear pointers to 0, set pkt_count=0, set state=STORE, and drive overflow=0 and debug_out.valid=0.
REQ-027 debug_in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 Reset mid-packet SHALL discard all stored flits, partial and complete; no stale flit SHALL appear after reset.

Configuration
REQ-029 Macro OSD_PKT_BUF_STATS_EN defined: the block SHALL add output pkt_fwd_cnt [15:0], incremented on each read with last=1, wrapping 0xFFFF->0x0000 and cleared by reset.
REQ-030 Macro OSD_PKT_BUF_STATS_EN undefined: the pkt_fwd_cnt port and its counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 DEPTH=16, out_ready=1, write flits 0x0011, 0x0022, 0x0033 (last on third) -> out valid first in the cycle after 0x0033 is written; three flits out in order, last on 0x0033 only.
REQ-032 out_ready=0, write four 2-flit packets -> pkt_count=4 and in_ready=1; write 8 more single-flit packets -> pkt_count=12, full, in_ready=0.
REQ-033 DEPTH=16, write a 20-flit packet with out_ready=0 until full -> overflow pulses once and state=CUT; raise out_ready -> all 20 flits out in order, and STORE is re-entered after last is read.
REQ-034 Last flit of packet B written in the same cycle packet A's last flit is read, pkt_count=1 before -> pkt_count stays 1.
REQ-035 Write 2 of 3 flits, pull rst_n low for one cycle, then send 1-flit packet 0x00AA -> only 0x00AA is output, pkt_count returns to 0.
REQ-036 With OSD_PKT_BUF_STATS_EN, forward 5 packets -> pkt_fwd_cnt=5; force the count to 0xFFFF, forward 1 packet -> 0x0000.

Source files
------------

// File: rtl/osd_dii_pkt_buffer.sv
// Packet buffer for DII debug flits. It stores whole packets and forwards them, and switches
// to cut-through when a single packet fills the buffer. Optional macro: OSD_PKT_BUF_STATS_EN.
package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_dii_pkt_buffer
    import osd_dii_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  dii_flit                  debug_in,
    output logic                     debug_in_ready,
    output dii_flit                  debug_out,
    input  logic                     debug_out_ready,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     overflow
`ifdef OSD_PKT_BUF_STATS_EN
    ,
    output logic [15:0]              pkt_fwd_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {STORE, CUT} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] pkt_cnt_q, pkt_cnt_d;
    logic [16:0] mem_q [DEPTH];
    logic        empty, full, wr_en, rd_en, rd_last, out_valid;

    assign empty          = (wr_ptr_q == rd_ptr_q);
    assign full           = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign debug_in_ready = !full;
    assign wr_en          = debug_in.valid && !full;
    assign rd_last        = mem_q[rd_ptr_q[AW-1:0]][16];
    assign rd_en          = out_valid && debug_out_ready;
    assign debug_out      = {out_valid, mem_q[rd_ptr_q[AW-1:0]]};
    assign pkt_count      = pkt_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        // A packet completing and one leaving in the same cycle cancel out
        case ({wr_en && debug_in.last, rd_en && rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Flit storage holds no reset: the cleared pointers make old contents unreachable
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {debug_in.last, debug_in.data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= STORE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STORE: if (full && pkt_cnt_q == '0) state_d = CUT;
            CUT:   if (rd_en && rd_last)        state_d = STORE;
            default: state_d = STORE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        overflow  = 1'b0;
        case (state_q)
            STORE: begin
                out_valid = !empty && (pkt_cnt_q != '0);
                overflow  = full && (pkt_cnt_q == '0);
            end
            CUT:     out_valid = !empty;
            default: out_valid = 1'b0;
        endcase
    end

`ifdef OSD_PKT_BUF_STATS_EN
    logic [15:0] fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)               fwd_cnt_q <= '0;
        else if (rd_en && rd_last) fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end

    assign pkt_fwd_cnt = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_osd_dii_pkt_buffer.sv
// Directed bench for osd_dii_pkt_buffer. A scoreboard queue holds each accepted flit, and every
// flit read out is popped from it and compared.
module tb_osd_dii_pkt_buffer;
    import osd_dii_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    dii_flit     din, dout;
    logic        din_rdy, out_rdy, ovf;
    logic [4:0]  pcnt;
`ifdef OSD_PKT_BUF_STATS_EN
    logic [15:0] fwd_cnt;
`endif

    logic [16:0] sbq [$];
    int          n_cmp = 0, n_err = 0, model_pkts = 0, ovf_pulses = 0;
    logic        acc;

    always #5 clk = ~clk;

    osd_dii_pkt_buffer #(.DEPTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .debug_in        (din),
        .debug_in_ready  (din_rdy),
        .debug_out       (dout),
        .debug_out_ready (out_rdy),
        .pkt_count       (pcnt),
        .overflow        (ovf)
`ifdef OSD_PKT_BUF_STATS_EN
        ,
        .pkt_fwd_cnt     (fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. It starts at a negedge with the inputs already driven, runs the
    // scoreboard on the read and write that the coming posedge commits, and ends at the next negedge.
    task automatic tick();
        logic [16:0] exp;
        #1;
        if (dout.valid === 1'b1 && out_rdy) begin
            if (sbq.size() == 0) chk("spurious_out", 32'(sbq.size()), 32'd1);
            else begin
                exp = sbq.pop_front();
                chk("out_flit", 32'({dout.last, dout.data}), 32'(exp));
                if (exp[16]) model_pkts--;
            end
        end
        acc = din.valid && (din_rdy === 1'b1);
        if (acc) begin
            sbq.push_back({din.last, din.data});
            if (din.last) model_pkts++;
        end
        if (ovf === 1'b1) ovf_pulses++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        din = '{valid: 1'b1, last: l, data: d};
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        din.valid = 1'b0;
    endtask

    task automatic drain();
        out_rdy = 1'b1;
        for (int k = 0; k < 100 && sbq.size() != 0; k++) tick();
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        chk("drained_valid", 32'(dout.valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; out_rdy = 1'b0; din = '0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(dout.valid), 32'd0);
        chk("rst_ready", 32'(din_rdy), 32'd1);
        chk("rst_pcnt", 32'(pcnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // three-flit packet, store-and-forward latency
        out_rdy = 1'b1;
        send(16'h0011, 1'b0);
        chk("store_hold1", 32'(dout.valid), 32'd0);
        send(16'h0022, 1'b0);
        chk("store_hold2", 32'(dout.valid), 32'd0);
        send(16'h0033, 1'b1);
        chk("first_valid", 32'(dout.valid), 32'd1);
        chk("pcnt_one", 32'(pcnt), 32'd1);
        drain();
        chk("pcnt_after3", 32'(pcnt), 32'd0);

        // fill the buffer with complete packets
        out_rdy = 1'b0;
        for (int p = 0; p < 4; p++) begin
            send(16'h2000 + 16'(2*p), 1'b0);
            send(16'h2001 + 16'(2*p), 1'b1);
        end
        chk("pcnt_4", 32'(pcnt), 32'd4);
        chk("ready_4", 32'(din_rdy), 32'd1);
        for (int i = 0; i < 8; i++) send(16'h3000 + 16'(i), 1'b1);
        chk("pcnt_12", 32'(pcnt), 32'd12);
        chk("full_ready", 32'(din_rdy), 32'd0);
        chk("full_ovf_cnt", 32'(ovf_pulses), 32'd0);
        // a write offered while full is rejected, even though a read happens in the same cycle
        din = '{valid: 1'b1, last: 1'b1, data: 16'hDEAD};
        out_rdy = 1'b1;
        tick();
        din.valid = 1'b0; out_rdy = 1'b0;
        chk("no_bypass_acc", 32'(acc), 32'd0);
        chk("no_bypass_pcnt", 32'(pcnt), 32'(model_pkts));
        chk("ready_after_rd", 32'(din_rdy), 32'd1);
        drain();
        chk("pcnt_drained", 32'(pcnt), 32'd0);

        // a 20-flit packet is larger than the buffer, which forces cut-through
        begin
            int i = 0;
            out_rdy = 1'b0;
            for (int c = 0; c < 40 && i < 16; c++) begin
                din = '{valid: 1'b1, last: 1'b0, data: 16'h0100 + 16'(i)};
                tick();
                if (acc) i++;
            end
            din = '{valid: 1'b1, last: 1'b0, data: 16'h0100 + 16'(i)};
            tick(); tick();
            chk("ovf_once", 32'(ovf_pulses), 32'd1);
            chk("cut_full", 32'(din_rdy), 32'd0);
            chk("cut_valid", 32'(dout.valid), 32'd1);
            chk("cut_pcnt", 32'(pcnt), 32'd0);
            out_rdy = 1'b1;
            for (int c = 0; c < 60 && i < 20; c++) begin
                din = '{valid: 1'b1, last: (i == 19), data: 16'h0100 + 16'(i)};
                tick();
                if (acc) i++;
            end
            din.valid = 1'b0;
            chk("big_written", 32'(i), 32'd20);
            drain();
            chk("ovf_still_once", 32'(ovf_pulses), 32'd1);
            send(16'h0200, 1'b0);
            chk("store_reentered", 32'(dout.valid), 32'd0);
            send(16'h0201, 1'b1);
            drain();
        end

        // A's last flit is read in the same cycle that B's last flit is written
        out_rdy = 1'b0;
        send(16'h0A01, 1'b1);
        send(16'h0B01, 1'b0);
        chk("pcnt_pre_simul", 32'(pcnt), 32'd1);
        din = '{valid: 1'b1, last: 1'b1, data: 16'h0B02};
        out_rdy = 1'b1;
        tick();
        din.valid = 1'b0; out_rdy = 1'b0;
        chk("simul_acc", 32'(acc), 32'd1);
        chk("simul_pcnt", 32'(pcnt), 32'd1);
        drain();

        // reset in the middle of a packet
        out_rdy = 1'b0;
        send(16'h0C01, 1'b0);
        send(16'h0C02, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sbq.delete();
        model_pkts = 0;
        chk("midrst_valid", 32'(dout.valid), 32'd0);
        chk("midrst_pcnt", 32'(pcnt), 32'd0);
        chk("midrst_ready", 32'(din_rdy), 32'd1);
        out_rdy = 1'b1;
        send(16'h00AA, 1'b1);
        drain();
        chk("midrst_pcnt_end", 32'(pcnt), 32'd0);

`ifdef OSD_PKT_BUF_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("fwd_rst", 32'(fwd_cnt), 32'd0);
        out_rdy = 1'b1;
        for (int p = 0; p < 5; p++) send(16'h0500 + 16'(p), 1'b1);
        drain();
        chk("fwd_5", 32'(fwd_cnt), 32'd5);
        force dut.fwd_cnt_q = 16'hFFFF;
        #1;
        release dut.fwd_cnt_q;
        send(16'h0600, 1'b1);
        drain();
        chk("fwd_wrap", 32'(fwd_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
